pcs_loopback_bist_ctrl: RTL and testbench

Built-in self-test sequencer for the 10GBASE-R PCS receive path in line-loopback setups. It generates a fixed 64-bit pattern stream with sync headers and optionally corrupts one header at a programmable rate. It waits for `rx_block_lock` to be acquired, then compares the looped-back data against a latency-matched copy of what it sent. It monitors `rx_high_ber` and `rx_error_count` and reports a single pass/fail verdict plus counters. It sits beside `eth_phy_10g`, driving the SERDES-side receive inputs and observing the PCS status outputs.

---
 rtl/pcs_bist_pkg.sv | 27 ++
 rtl/pcs_bist_delay_line.sv | 35 +++
 rtl/pcs_loopback_bist_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pcs_loopback_bist_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pcs_bist_pkg.sv
// Shared types and constants for the PCS loopback BIST sequencer.
package pcs_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRIME = 3'd1,
    ST_CHECK = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } bist_state_e;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_CTRL = 2'b01;

  localparam int PATTERN_NUM  = 6;
  localparam int PATTERN_IDLE = 5;

  localparam logic [63:0] PATTERN_ROM [PATTERN_NUM] = '{
    64'hFFFF_FFFF_FFFF_FFFF,
    64'h0000_0000_0000_0000,
    64'h5555_5555_5555_5555,
    64'hAAAA_AAAA_AAAA_AAAA,
    64'hFEFE_FEFE_FEFE_FEFE,
    64'h0707_0707_0707_0707
  };

endpackage

// File: rtl/pcs_bist_delay_line.sv
// Expected-data pipe: LATENCY-deep data+valid shift register, output is the input LATENCY cycles ago.
// No backpressure; shifts every cycle.
module pcs_bist_delay_line #(
  parameter int DATA_WIDTH = 64,
  parameter int LATENCY    = 7
) (
  input  logic                  rx_clk,
  input  logic                  rx_rst_n,
  input  logic [DATA_WIDTH-1:0] in_dat,
  input  logic                  in_vld,
  output logic [DATA_WIDTH-1:0] out_dat,
  output logic                  out_vld
);

  logic [DATA_WIDTH-1:0] dat_q [LATENCY];
  logic [LATENCY-1:0]    vld_q;

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      for (int i = 0; i < LATENCY; i++) dat_q[i] <= '0;
      vld_q <= '0;
    end else begin
      dat_q[0] <= in_dat;
      vld_q[0] <= in_vld;
      for (int i = 1; i < LATENCY; i++) begin
        dat_q[i] <= dat_q[i-1];
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  assign out_dat = dat_q[LATENCY-1];
  assign out_vld = vld_q[LATENCY-1];

endmodule

// File: rtl/pcs_loopback_bist_ctrl.sv
// Loopback BIST for the 10GBASE-R PCS receive path: pattern generation, header corruption, compare, verdict.
// All outputs registered; first pattern one cycle after cfg_start; no backpressure.
module pcs_loopback_bist_ctrl
  import pcs_bist_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int HDR_WIDTH    = 2,
  parameter int LATENCY      = 7,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int TEST_LEN     = 512
) (
  input  logic                  rx_clk,
  input  logic                  rx_rst_n,
  input  logic                  cfg_start,
  input  logic                  cfg_abort,
  input  logic [15:0]           cfg_corrupt_period,
  input  logic [HDR_WIDTH-1:0]  cfg_corrupt_hdr,
  output logic [DATA_WIDTH-1:0] gen_data,
  output logic [HDR_WIDTH-1:0]  gen_hdr,
  input  logic [DATA_WIDTH-1:0] chk_data,
  input  logic                  rx_block_lock,
  input  logic                  rx_high_ber,
  input  logic [6:0]            rx_error_count,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [2:0]            state,
  output logic [15:0]           pattern_error_count,
  output logic [15:0]           hdr_inject_count,
  output logic [6:0]            max_rx_error_count
);

  bist_state_e           state_q, state_nxt;
  logic [15:0]           phase_cnt, per_cnt, per_val;
  logic [2:0]            pat_idx, pat_idx_d;
  logic                  fail_lock, lost_lock, saw_high_ber;
  logic                  fail_lock_d, lost_lock_d, saw_high_ber_d;
  logic                  start_run, corrupt, gen_on;
  logic [DATA_WIDTH-1:0] gen_data_d, exp_dat;
  logic [HDR_WIDTH-1:0]  gen_hdr_d;
  logic                  exp_vld, busy_d, done_d, pass_d;
  logic [15:0]           err_cnt_d, inj_cnt_d;
  logic [6:0]            max_err_d;

  pcs_bist_delay_line #(.DATA_WIDTH(DATA_WIDTH), .LATENCY(LATENCY)) u_exp_pipe (
    .rx_clk   (rx_clk),
    .rx_rst_n (rx_rst_n),
    .in_dat   (gen_data),
    .in_vld   (state_q == ST_CHECK),
    .out_dat  (exp_dat),
    .out_vld  (exp_vld)
  );

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state_q   <= ST_IDLE;
      phase_cnt <= '0;
    end else begin
      state_q   <= state_nxt;
      phase_cnt <= (state_nxt != state_q) ? 16'd0 : phase_cnt + 16'd1;
    end
  end

  // phase_cnt counts cycles already spent in the current state, so the current cycle is phase_cnt+1.
  always_comb begin
    state_nxt = state_q;
    if (cfg_abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: if (cfg_start) state_nxt = ST_PRIME;
        ST_PRIME: begin
          if (rx_block_lock && phase_cnt >= 16'(LATENCY - 1))  state_nxt = ST_CHECK;
          else if (phase_cnt >= 16'(LOCK_TIMEOUT - 1))         state_nxt = ST_DONE;
        end
        ST_CHECK: if (phase_cnt >= 16'(TEST_LEN - 1)) state_nxt = ST_DRAIN;
        ST_DRAIN: if (phase_cnt >= 16'(LATENCY - 1))  state_nxt = ST_DONE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    start_run = (state_nxt == ST_PRIME) && (state_q != ST_PRIME);
    gen_on    = (state_nxt == ST_PRIME) || (state_nxt == ST_CHECK) || (state_nxt == ST_DRAIN);

    // The >= keeps the timer sane if the period shrinks mid-run.
    per_val = 16'd0;
    if (state_q == ST_CHECK && per_cnt < cfg_corrupt_period - 16'd1) per_val = per_cnt + 16'd1;
    corrupt = (state_nxt == ST_CHECK) && (cfg_corrupt_period != 16'd0) &&
              (per_val == cfg_corrupt_period - 16'd1);

    pat_idx_d  = pat_idx;
    gen_data_d = DATA_WIDTH'(PATTERN_ROM[PATTERN_IDLE]);
    if (start_run) begin
      pat_idx_d  = 3'd1;
      gen_data_d = DATA_WIDTH'(PATTERN_ROM[0]);
    end else if (gen_on) begin
      pat_idx_d  = (pat_idx == 3'(PATTERN_NUM - 1)) ? 3'd0 : pat_idx + 3'd1;
      gen_data_d = DATA_WIDTH'(PATTERN_ROM[pat_idx]);
    end
    gen_hdr_d = corrupt ? cfg_corrupt_hdr : HDR_WIDTH'(SYNC_DATA);

    err_cnt_d      = pattern_error_count;
    inj_cnt_d      = hdr_inject_count;
    max_err_d      = max_rx_error_count;
    fail_lock_d    = fail_lock;
    lost_lock_d    = lost_lock;
    saw_high_ber_d = saw_high_ber;
    if (start_run) begin
      err_cnt_d      = '0;
      inj_cnt_d      = '0;
      max_err_d      = '0;
      fail_lock_d    = 1'b0;
      lost_lock_d    = 1'b0;
      saw_high_ber_d = 1'b0;
    end else if (!cfg_abort) begin
      if ((state_q == ST_CHECK || state_q == ST_DRAIN) && exp_vld &&
          exp_dat != chk_data && pattern_error_count != 16'hFFFF)
        err_cnt_d = pattern_error_count + 16'd1;
      if (corrupt && hdr_inject_count != 16'hFFFF) inj_cnt_d = hdr_inject_count + 16'd1;
      if (state_q == ST_CHECK) begin
        if (!rx_block_lock) lost_lock_d = 1'b1;
        if (rx_high_ber)    saw_high_ber_d = 1'b1;
        if (rx_error_count > max_rx_error_count) max_err_d = rx_error_count;
      end
      if (state_q == ST_PRIME && state_nxt == ST_DONE) fail_lock_d = 1'b1;
    end

    busy_d = (state_nxt == ST_PRIME) || (state_nxt == ST_CHECK);
    done_d = (state_nxt == ST_DONE);
    pass_d = done_d && !fail_lock_d && !lost_lock_d && !saw_high_ber_d && (err_cnt_d == 16'd0);
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      per_cnt             <= '0;
      pat_idx             <= '0;
      gen_data            <= DATA_WIDTH'(PATTERN_ROM[PATTERN_IDLE]);
      gen_hdr             <= HDR_WIDTH'(SYNC_DATA);
      pattern_error_count <= '0;
      hdr_inject_count    <= '0;
      max_rx_error_count  <= '0;
      fail_lock           <= 1'b0;
      lost_lock           <= 1'b0;
      saw_high_ber        <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
      pass                <= 1'b0;
    end else begin
      if (state_nxt == ST_CHECK) per_cnt <= per_val;
      pat_idx             <= pat_idx_d;
      gen_data            <= gen_data_d;
      gen_hdr             <= gen_hdr_d;
      pattern_error_count <= err_cnt_d;
      hdr_inject_count    <= inj_cnt_d;
      max_rx_error_count  <= max_err_d;
      fail_lock           <= fail_lock_d;
      lost_lock           <= lost_lock_d;
      saw_high_ber        <= saw_high_ber_d;
      busy                <= busy_d;
      done                <= done_d;
      pass                <= pass_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pcs_loopback_bist_ctrl.sv
// Directed bench for pcs_loopback_bist_ctrl with a 7-cycle ideal loopback model.
module tb_pcs_loopback_bist_ctrl;

  logic        rx_clk, rx_rst_n, cfg_start, cfg_abort;
  logic [15:0] cfg_corrupt_period;
  logic [1:0]  cfg_corrupt_hdr, gen_hdr;
  logic [63:0] gen_data, chk_data;
  logic        rx_block_lock, rx_high_ber;
  logic [6:0]  rx_error_count, max_rx_error_count;
  logic        busy, done, pass;
  logic [2:0]  state;
  logic [15:0] pattern_error_count, hdr_inject_count;

  int n_cmp, n_fail;
  int prime_cyc, check_cyc, drain_cyc, hdr_bad, first_bad, guard;
  int err_at20, err_at22;
  logic [63:0] hist [8];

  pcs_loopback_bist_ctrl dut (
    .rx_clk(rx_clk), .rx_rst_n(rx_rst_n), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_corrupt_period(cfg_corrupt_period), .cfg_corrupt_hdr(cfg_corrupt_hdr),
    .gen_data(gen_data), .gen_hdr(gen_hdr), .chk_data(chk_data),
    .rx_block_lock(rx_block_lock), .rx_high_ber(rx_high_ber), .rx_error_count(rx_error_count),
    .busy(busy), .done(done), .pass(pass), .state(state),
    .pattern_error_count(pattern_error_count), .hdr_inject_count(hdr_inject_count),
    .max_rx_error_count(max_rx_error_count)
  );

  initial rx_clk = 1'b0;
  always #5 rx_clk = ~rx_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: advance past the edge, feed back gen_data from 7 cycles ago, tally state occupancy.
  task automatic step();
    @(posedge rx_clk);
    #1;
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0]  = gen_data;
    chk_data = hist[7];
    if (state == 3'd1) prime_cyc++;
    if (state == 3'd2) check_cyc++;
    if (state == 3'd3) drain_cyc++;
    if (gen_hdr != 2'b10) begin
      hdr_bad++;
      if (first_bad == 0) first_bad = check_cyc;
    end
  endtask

  task automatic start_run();
    prime_cyc = 0; check_cyc = 0; drain_cyc = 0; hdr_bad = 0; first_bad = 0; guard = 0;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    for (int i = 0; i < 8; i++) hist[i] = '0;
    rx_rst_n = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0;
    cfg_corrupt_period = 16'd0; cfg_corrupt_hdr = 2'b11;
    chk_data = '0; rx_block_lock = 1'b0; rx_high_ber = 1'b0; rx_error_count = '0;
    repeat (2) @(posedge rx_clk);
    #1;
    chk("rst_state", state, 64'd0);
    chk("rst_busy", busy, 64'd0);
    chk("rst_done", done, 64'd0);
    chk("rst_pass", pass, 64'd0);
    chk("rst_gen_data", gen_data, 64'h0707_0707_0707_0707);
    chk("rst_gen_hdr", gen_hdr, 64'd2);
    chk("rst_err_cnt", pattern_error_count, 64'd0);
    chk("rst_inj_cnt", hdr_inject_count, 64'd0);
    chk("rst_max_err", max_rx_error_count, 64'd0);
    rx_rst_n = 1'b1;
    step();

    // Ideal loopback, lock after 20 PRIME cycles, pattern order and wrap
    start_run();
    chk("t1_state_prime", state, 64'd1);
    chk("t1_busy", busy, 64'd1);
    chk("t1_pat0", gen_data, 64'hFFFF_FFFF_FFFF_FFFF);
    step(); chk("t1_pat1", gen_data, 64'h0000_0000_0000_0000);
    step(); chk("t1_pat2", gen_data, 64'h5555_5555_5555_5555);
    step(); chk("t1_pat3", gen_data, 64'hAAAA_AAAA_AAAA_AAAA);
    step(); chk("t1_pat4", gen_data, 64'hFEFE_FEFE_FEFE_FEFE);
    step(); chk("t1_pat5", gen_data, 64'h0707_0707_0707_0707);
    step(); chk("t1_pat_wrap", gen_data, 64'hFFFF_FFFF_FFFF_FFFF);
    while (!done && guard < 2000) begin
      step(); guard++;
      if (prime_cyc == 20) rx_block_lock = 1'b1;
    end
    chk("t1_done", done, 64'd1);
    chk("t1_state_done", state, 64'd4);
    chk("t1_prime_len", prime_cyc, 64'd20);
    chk("t1_check_len", check_cyc, 64'd512);
    chk("t1_drain_len", drain_cyc, 64'd7);
    chk("t1_pass", pass, 64'd1);
    chk("t1_err_cnt", pattern_error_count, 64'd0);
    chk("t1_inj_cnt", hdr_inject_count, 64'd0);
    chk("t1_busy_done", busy, 64'd0);

    // Light corruption: every 16th header, restart straight from DONE
    cfg_corrupt_period = 16'd16; cfg_corrupt_hdr = 2'b11;
    start_run();
    while (!done && guard < 2000) begin step(); guard++; end
    chk("t2_done", done, 64'd1);
    chk("t2_prime_len", prime_cyc, 64'd7);
    chk("t2_inj_cnt", hdr_inject_count, 64'd32);
    chk("t2_hdr_seen", hdr_bad, 64'd32);
    chk("t2_first_corrupt", first_bad, 64'd16);
    chk("t2_err_cnt", pattern_error_count, 64'd0);
    chk("t2_pass", pass, 64'd1);
    cfg_abort = 1'b1; step(); cfg_abort = 1'b0;
    chk("t2_abort_state", state, 64'd0);
    chk("t2_abort_pass", pass, 64'd0);
    chk("t2_abort_inj_hold", hdr_inject_count, 64'd32);

    // Data flips on three CHECK cycles
    cfg_corrupt_period = 16'd0;
    start_run();
    while (!done && guard < 2000) begin
      step(); guard++;
      if (state == 3'd2 && check_cyc == 20) err_at20 = int'(pattern_error_count);
      if (state == 3'd2 && check_cyc == 22) err_at22 = int'(pattern_error_count);
      if (state == 3'd2 && (check_cyc == 20 || check_cyc == 21 || check_cyc == 100))
        chk_data[0] = ~chk_data[0];
    end
    chk("t3_done", done, 64'd1);
    chk("t3_err_before", err_at20, 64'd0);
    chk("t3_err_latency", err_at22, 64'd2);
    chk("t3_err_cnt", pattern_error_count, 64'd3);
    chk("t3_pass", pass, 64'd0);

    // Lock timeout
    rx_block_lock = 1'b0;
    start_run();
    while (!done && guard < 1100) begin step(); guard++; end
    chk("t4_done", done, 64'd1);
    chk("t4_prime_len", prime_cyc, 64'd1024);
    chk("t4_check_len", check_cyc, 64'd0);
    chk("t4_pass", pass, 64'd0);
    chk("t4_err_cnt", pattern_error_count, 64'd0);

    // Lost lock, high BER and error-count peak
    rx_block_lock = 1'b1;
    start_run();
    while (!done && guard < 2000) begin
      step(); guard++;
      if (state == 3'd2) begin
        if (check_cyc == 30) rx_block_lock = 1'b0;
        if (check_cyc == 31) rx_block_lock = 1'b1;
        if (check_cyc == 40) rx_high_ber = 1'b1;
        if (check_cyc == 41) rx_high_ber = 1'b0;
        if (check_cyc == 50) rx_error_count = 7'd4;
        if (check_cyc == 60) rx_error_count = 7'd9;
        if (check_cyc == 70) rx_error_count = 7'd3;
      end
      if (state == 3'd3) rx_error_count = 7'd100;
    end
    rx_error_count = 7'd0;
    chk("t5_done", done, 64'd1);
    chk("t5_max_err", max_rx_error_count, 64'd9);
    chk("t5_err_cnt", pattern_error_count, 64'd0);
    chk("t5_pass", pass, 64'd0);

    // Abort mid-CHECK, then start+abort together in IDLE
    cfg_corrupt_period = 16'd16; cfg_corrupt_hdr = 2'b00;
    start_run();
    while (check_cyc < 40 && guard < 200) begin step(); guard++; end
    cfg_abort = 1'b1; step(); cfg_abort = 1'b0;
    chk("t6_abort_state", state, 64'd0);
    chk("t6_abort_busy", busy, 64'd0);
    chk("t6_abort_pass", pass, 64'd0);
    chk("t6_abort_inj", hdr_inject_count, 64'd2);
    step(); step();
    chk("t6_idle_data", gen_data, 64'h0707_0707_0707_0707);
    chk("t6_idle_hdr", gen_hdr, 64'd2);
    chk("t6_inj_hold", hdr_inject_count, 64'd2);
    cfg_start = 1'b1; cfg_abort = 1'b1; step(); cfg_start = 1'b0; cfg_abort = 1'b0;
    chk("t6_both_state", state, 64'd0);
    chk("t6_both_busy", busy, 64'd0);
    chk("t6_both_inj_hold", hdr_inject_count, 64'd2);

    // Corrupt every cycle, then reset mid-CHECK
    cfg_corrupt_period = 16'd1;
    start_run();
    while (check_cyc < 10 && guard < 200) begin step(); guard++; end
    chk("t7_inj_every", hdr_inject_count, 64'd10);
    chk("t7_hdr_every", gen_hdr, 64'd0);
    rx_rst_n = 1'b0;
    #2;
    chk("t7_rst_state", state, 64'd0);
    chk("t7_rst_busy", busy, 64'd0);
    chk("t7_rst_data", gen_data, 64'h0707_0707_0707_0707);
    chk("t7_rst_hdr", gen_hdr, 64'd2);
    chk("t7_rst_inj", hdr_inject_count, 64'd0);
    chk("t7_rst_max", max_rx_error_count, 64'd0);
    #2;
    rx_rst_n = 1'b1;
    step();
    chk("t7_post_state", state, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
